// File: rtl/sum_gather_8.sv
`default_nettype none
// ============================================================================
// Module      : sum_gather_8
// Description : Stream-to-frame gatherer. Packs 32-bit stream words into
//               8-word frames presented in parallel for a combinational
//               8-input summer. Double-buffered: a fill bank collects the
//               next frame while the output bank waits for the consumer.
//               Frames closed early by in_last are zero-padded.
// Ports       : clk, rst_n (sync, active-low)
//               in_data/in_valid/in_last/in_ready : input word stream
//               w_0..w_7, out_count, out_valid/out_ready : frame output
// Revision    : 1.0 - initial release
// ============================================================================
module sum_gather_8 #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [LEN-1:0] in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [LEN-1:0] w_0,
    output logic [LEN-1:0] w_1,
    output logic [LEN-1:0] w_2,
    output logic [LEN-1:0] w_3,
    output logic [LEN-1:0] w_4,
    output logic [LEN-1:0] w_5,
    output logic [LEN-1:0] w_6,
    output logic [LEN-1:0] w_7,
    output logic [3:0]     out_count,
    output logic           out_valid,
    input  logic           out_ready
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [LEN-1:0] r_fill [8];
    logic [LEN-1:0] r_out  [8];
    logic [2:0]     r_idx;
    logic [3:0]     r_fcnt;
    logic [3:0]     r_out_count;
    logic           r_out_valid;

    logic           w_beat;
    logic           w_close;
    logic           w_xfer;

    // in_ready depends on registered state only, so no combinational path
    // from the consumer back to the producer.
    assign in_ready = (r_state == S_FILL);
    assign w_beat   = in_valid && in_ready;
    assign w_close  = w_beat && ((r_idx == 3'd7) || in_last);
    // The output bank is free when empty or being drained this very cycle.
    assign w_xfer   = (r_state == S_FULL) && (!r_out_valid || out_ready);

    // ------------------------------------------------------------------
    // Fill state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (w_close) w_state_next = S_FULL;
            S_FULL:  if (w_xfer)  w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Fill side: index and word count of the frame being collected
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= 3'd0;
            r_fcnt <= 4'd0;
        end else if (w_beat) begin
            if (w_close) begin
                r_idx  <= 3'd0;
                r_fcnt <= {1'b0, r_idx} + 4'd1;
            end else begin
                r_idx  <= r_idx + 3'd1;
            end
        end
    end

    // Fill bank carries no reset: entries at or above r_fcnt are masked to
    // zero on transfer, so stale contents can never reach the outputs.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_fill[r_idx] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Output bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_out[k] <= '0;
            end
        end else if (w_xfer) begin
            for (int k = 0; k < 8; k++) begin
                r_out[k] <= (k < int'(r_fcnt)) ? r_fill[k] : '0;
            end
        end
    end

    // A coinciding handshake and transfer keeps out_valid high: the new
    // frame replaces the consumed one with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_count <= 4'd0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_count <= r_fcnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_0       = r_out[0];
    assign w_1       = r_out[1];
    assign w_2       = r_out[2];
    assign w_3       = r_out[3];
    assign w_4       = r_out[4];
    assign w_5       = r_out[5];
    assign w_6       = r_out[6];
    assign w_7       = r_out[7];
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sum_gather_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_gather_8
// Description : Self-checking bench for sum_gather_8. A queue-based frame
//               scoreboard groups accepted words into expected frames and
//               compares every consumed output frame; directed sections
//               check reset, latency, padding, backpressure and sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_gather_8;

    localparam int LEN = 32;

    logic           clk;
    logic           rst_n;
    logic [LEN-1:0] in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [LEN-1:0] w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7;
    logic [3:0]     out_count;
    logic           out_valid;
    logic           out_ready;

    sum_gather_8 #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .w_0       (w_0),
        .w_1       (w_1),
        .w_2       (w_2),
        .w_3       (w_3),
        .w_4       (w_4),
        .w_5       (w_5),
        .w_6       (w_6),
        .w_7       (w_7),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [LEN-1:0] w_arr [8];
    assign w_arr[0] = w_0;
    assign w_arr[1] = w_1;
    assign w_arr[2] = w_2;
    assign w_arr[3] = w_3;
    assign w_arr[4] = w_4;
    assign w_arr[5] = w_5;
    assign w_arr[6] = w_6;
    assign w_arr[7] = w_7;

    typedef struct {
        logic [LEN-1:0] w [8];
        int             cnt;
    } frame_t;

    frame_t         exp_q [$];
    logic [LEN-1:0] cur   [$];

    int             n_cmp = 0;
    int             n_err = 0;

    bit             p_stall = 1'b0;
    logic [LEN-1:0] p_w [8];
    logic [3:0]     p_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL %s: observed timeout expected handshake", tag);
    endtask

    function automatic logic [LEN-1:0] wsum();
        logic [LEN-1:0] s = '0;
        for (int k = 0; k < 8; k++) s = s + w_arr[k];
        return s;
    endfunction

    // Evaluate the model for the current cycle, then advance one clock.
    task automatic tick();
        frame_t f;
        bit     stall = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            cur.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    f = exp_q.pop_front();
                    for (int k = 0; k < 8; k++)
                        check($sformatf("frame_w%0d", k), w_arr[k], f.w[k]);
                    check("frame_count", out_count, f.cnt);
                end
            end
            if (in_valid && in_ready) begin
                cur.push_back(in_data);
                if (in_last || cur.size() == 8) begin
                    for (int k = 0; k < 8; k++)
                        f.w[k] = (k < cur.size()) ? cur[k] : '0;
                    f.cnt = cur.size();
                    exp_q.push_back(f);
                    cur.delete();
                end
            end
            stall = out_valid && !out_ready;
            for (int k = 0; k < 8; k++) p_w[k] = w_arr[k];
            p_cnt = out_count;
        end
        p_stall = stall;
        @(posedge clk);
        #1;
        if (p_stall && rst_n) begin
            check("hold_valid", out_valid, 1'b1);
            for (int k = 0; k < 8; k++)
                check($sformatf("hold_w%0d", k), w_arr[k], p_w[k]);
            check("hold_count", out_count, p_cnt);
        end
    endtask

    task automatic send(input logic [LEN-1:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) timeout_fail("send");
        else tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) timeout_fail("wait_out");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_count"}, out_count, 4'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_w%0d", tag, k), w_arr[k], '0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int sent;
        int cyc;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_outputs_zero("reset");

        // Full frame 1..8 back to back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(LEN'(i), 1'b0);
        check("full_in_ready_low", in_ready, 1'b0);
        check("full_valid_early", out_valid, 1'b0);
        tick();
        check("full_valid", out_valid, 1'b1);
        check("full_in_ready_back", in_ready, 1'b1);
        check("full_count", out_count, 4'd8);
        check("full_sum", wsum(), 32'd36);
        tick();

        // Short frames
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        send(32'd7, 1'b1);
        wait_out();
        check("short_w0", w_0, 32'd5);
        check("short_w2", w_2, 32'd7);
        check("short_w3", w_3, 32'd0);
        check("short_w7", w_7, 32'd0);
        check("short_count", out_count, 4'd3);
        check("short_sum", wsum(), 32'd18);
        tick();
        send(32'd9, 1'b1);
        wait_out();
        check("single_count", out_count, 4'd1);
        check("single_w0", w_0, 32'd9);
        check("single_sum", wsum(), 32'd9);
        tick();

        // Backpressure: A held while B completes, C refused
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'hFFFF_FFFF, 1'b0);
        wait_out();
        check("bp_sum_a", wsum(), 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) send(LEN'(i), 1'b0);
        in_data  = 32'hC0C0_C0C0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_w0_a", w_0, 32'hFFFF_FFFF);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_valid_kept", out_valid, 1'b1);
        check("bp_b_w1", w_1, 32'd1);
        check("bp_b_w7", w_7, 32'd7);
        check("bp_b_count", out_count, 4'd8);
        check("bp_in_ready_back", in_ready, 1'b1);
        tick();

        // Simultaneous handshake and transfer
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(LEN'(10 + i), 1'b0);
        wait_out();
        send(32'd20, 1'b0);
        send(32'd21, 1'b0);
        send(32'd22, 1'b1);
        check("sim_full", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        check("sim_valid", out_valid, 1'b1);
        check("sim_w0", w_0, 32'd20);
        check("sim_count", out_count, 4'd3);
        tick();

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send(LEN'(100 + i), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outputs_zero("midrst");
        for (int i = 1; i <= 8; i++) send(LEN'(i), 1'b0);
        wait_out();
        check("midrst_w0", w_0, 32'd1);
        check("midrst_sum", wsum(), 32'd36);
        tick();

        // Random throttling
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_last   = (sent == 999) ? 1'b1 : ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        check("random_words", sent, 1000);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        check("drain_frames", exp_q.size(), 0);
        check("drain_partial", cur.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
